// File: rtl/fw_result_drain.sv
// fw_result_drain
// Receives 64-bit result words from the fw core and buffers them in a FIFO.
// Each word is unpacked into W-bit elements tagged with their matrix
// row/column, and the elements are handed to the host over valid/ready.
// Also provides matrix boundary marking, an almost_full throttle for
// upstream, a sticky overflow flag and a count of completed matrices.
module fw_result_drain #(
  parameter int unsigned N         = 8,
  parameter int unsigned W         = 16,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AF_MARGIN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          inD,
  input  logic                 in_valid,
  output logic [W-1:0]         el_data,
  output logic [$clog2(N)-1:0] el_row,
  output logic [$clog2(N)-1:0] el_col,
  output logic                 el_last,
  output logic                 el_valid,
  input  logic                 el_ready,
  output logic                 almost_full,
  output logic                 overflow,
  output logic [7:0]           matrix_count,
  output logic                 busy
);

  localparam int unsigned LANES = 64 / W;
  localparam int unsigned LW    = $clog2(LANES);
  localparam int unsigned IW    = $clog2(N);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;

  localparam logic [CW-1:0] C_FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF       = CW'(DEPTH - AF_MARGIN);
  localparam logic [LW-1:0] C_LANE_END = LW'(LANES - 1);
  localparam logic [IW-1:0] C_IDX_END  = IW'(N - 1);

  // FIFO state
  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Unpack register
  logic [63:0]   r_word;
  logic [LW-1:0] r_lane;
  logic          r_valid;

  // Element indexing and status
  logic [IW-1:0] r_row;
  logic [IW-1:0] r_col;
  logic [7:0]    r_mcount;
  logic          r_af;
  logic          r_ovf;
  logic          r_busy;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_drop;
  logic          w_xfer;
  logic          w_lane_end;
  logic          w_pop;
  logic          w_valid_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [W-1:0]  w_el_data;

  // Full is judged on pre-edge occupancy, so a write while full is dropped
  // even if the unpack register pops the head on the same edge.
  assign w_full      = (r_count == C_FULL);
  assign w_empty     = (r_count == '0);
  assign w_push      = in_valid && !w_full;
  assign w_drop      = in_valid && w_full;
  assign w_xfer      = r_valid && el_ready;
  assign w_lane_end  = (r_lane == C_LANE_END);
  // Reload when empty, or when the final lane leaves this cycle (no bubble).
  assign w_pop       = !w_empty && (!r_valid || (w_xfer && w_lane_end));
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Valid state of the unpack register after this edge
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_pop) begin
      w_valid_nxt = 1'b1;
    end else if (w_xfer && w_lane_end) begin
      w_valid_nxt = 1'b0;
    end
  end

  // Lane select from the held word
  always_comb begin
    w_el_data = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (r_lane == LW'(l)) begin
        w_el_data = r_word[l*W +: W];
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= inD;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Unpack register: load a word from the FIFO head, step lanes on transfers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word  <= '0;
      r_lane  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_pop) begin
        r_word <= r_mem[r_rd_ptr];
        r_lane <= '0;
      end else if (w_xfer && !w_lane_end) begin
        r_lane <= r_lane + LW'(1);
      end
    end
  end

  // Row/column indices and matrix counter advance on delivered elements only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row    <= '0;
      r_col    <= '0;
      r_mcount <= '0;
    end else if (w_xfer) begin
      if (r_col == C_IDX_END) begin
        r_col <= '0;
        if (r_row == C_IDX_END) begin
          r_row    <= '0;
          r_mcount <= r_mcount + 8'd1;
        end else begin
          r_row <= r_row + IW'(1);
        end
      end else begin
        r_col <= r_col + IW'(1);
      end
    end
  end

  // Status flags registered from post-edge occupancy; overflow is sticky
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_af   <= 1'b0;
      r_ovf  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_af   <= (w_count_nxt >= C_AF);
      r_busy <= (w_count_nxt != '0) || w_valid_nxt;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign el_data      = w_el_data;
  assign el_row       = r_row;
  assign el_col       = r_col;
  assign el_valid     = r_valid;
  assign el_last      = r_valid && (r_row == C_IDX_END) && (r_col == C_IDX_END);
  assign almost_full  = r_af;
  assign overflow     = r_ovf;
  assign matrix_count = r_mcount;
  assign busy         = r_busy;

endmodule

// File: tb/tb_fw_result_drain.sv
// tb_fw_result_drain
// Directed bench for fw_result_drain (N=8, W=16, DEPTH=32, AF_MARGIN=4).
// Test words carry their own position: word g, lane l holds
// ((g/16)%256)<<8 | ((g%16)*4 + l), so element e of the stream must read
// ((e/64)%256)<<8 | (e%64) at row (e%64)/8, column e%8.
module tb_fw_result_drain;

  localparam int unsigned N         = 8;
  localparam int unsigned W         = 16;
  localparam int unsigned DEPTH     = 32;
  localparam int unsigned AF_MARGIN = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] inD;
  logic        in_valid;
  logic [15:0] el_data;
  logic [2:0]  el_row;
  logic [2:0]  el_col;
  logic        el_last;
  logic        el_valid;
  logic        el_ready;
  logic        almost_full;
  logic        overflow;
  logic [7:0]  matrix_count;
  logic        busy;

  int unsigned n_vec  = 0;
  int unsigned n_err  = 0;
  int unsigned exp_e  = 0;
  logic [7:0]  exp_mc = '0;
  bit          chk_en = 1'b0;

  fw_result_drain #(
    .N        (N),
    .W        (W),
    .DEPTH    (DEPTH),
    .AF_MARGIN(AF_MARGIN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inD         (inD),
    .in_valid    (in_valid),
    .el_data     (el_data),
    .el_row      (el_row),
    .el_col      (el_col),
    .el_last     (el_last),
    .el_valid    (el_valid),
    .el_ready    (el_ready),
    .almost_full (almost_full),
    .overflow    (overflow),
    .matrix_count(matrix_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word(input int unsigned g);
    logic [63:0] v;
    v = '0;
    for (int unsigned l = 0; l < 4; l++) begin
      v[l*16 +: 16] = 16'(((g / 16) % 256) * 256 + (g % 16) * 4 + l);
    end
    return v;
  endfunction

  // One clock: drive inputs, check outputs against the element model, step.
  task automatic cycle(input logic v, input logic [63:0] d, input logic rdy);
    logic x;
    in_valid = v;
    inD      = d;
    el_ready = rdy;
    if (chk_en) begin
      chk("mcount", matrix_count, exp_mc);
      if (el_valid) begin
        chk("data", el_data, 64'(((exp_e / 64) % 256) * 256 + exp_e % 64));
        chk("row",  el_row,  64'((exp_e % 64) / 8));
        chk("col",  el_col,  64'(exp_e % 8));
        chk("last", el_last, 64'(exp_e % 64 == 63));
      end else begin
        chk("last_idle", el_last, 64'(0));
      end
    end
    x = el_valid && rdy;
    @(posedge clk);
    #1;
    if (x) begin
      if (exp_e % 64 == 63) exp_mc++;
      exp_e++;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    el_ready = 1'b0;
    inD      = '0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_e  = 0;
    exp_mc = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, el_valid, 64'(0));
    chk({tag, "_data"},  el_data, 64'(0));
    chk({tag, "_row"},   el_row, 64'(0));
    chk({tag, "_col"},   el_col, 64'(0));
    chk({tag, "_last"},  el_last, 64'(0));
    chk({tag, "_af"},    almost_full, 64'(0));
    chk({tag, "_ovf"},   overflow, 64'(0));
    chk({tag, "_busy"},  busy, 64'(0));
    chk({tag, "_mc"},    matrix_count, 64'(0));
  endtask

  initial begin
    logic [15:0] t1 [4];
    t1[0] = 16'h0000;
    t1[1] = 16'h003f;
    t1[2] = 16'h0047;
    t1[3] = 16'h0061;

    // Reset state
    do_reset();
    chk_all_zero("rst");

    // Single word, lanes out in order with one-edge latency
    chk_en = 1'b0;
    cycle(1'b1, 64'h0061_0047_003f_0000, 1'b1);
    chk("t1_lat_valid", el_valid, 64'(0));
    chk("t1_busy_on", busy, 64'(1));
    cycle(1'b0, '0, 1'b1);
    for (int unsigned l = 0; l < 4; l++) begin
      chk("t1_valid", el_valid, 64'(1));
      chk("t1_data", el_data, 64'(t1[l]));
      chk("t1_row", el_row, 64'(0));
      chk("t1_col", el_col, 64'(l));
      chk("t1_busy", busy, 64'(1));
      cycle(1'b0, '0, 1'b1);
    end
    chk("t1_valid_off", el_valid, 64'(0));
    chk("t1_busy_off", busy, 64'(0));
    chk("t1_col_next", el_col, 64'(4));

    // Full matrix at one word per cycle, no gaps
    do_reset();
    chk_en = 1'b1;
    for (int unsigned t = 0; t < 66; t++) begin
      cycle(t < 16, word(t), 1'b1);
      if (t == 0) chk("t2_lat", el_valid, 64'(0));
      if (t >= 1 && t <= 64) chk("t2_nogap", el_valid, 64'(1));
      chk("t2_af", almost_full, 64'(0));
    end
    chk("t2_done_valid", el_valid, 64'(0));
    chk("t2_mc", matrix_count, 64'(1));
    chk("t2_ovf", overflow, 64'(0));

    // Same matrix with a 20-cycle stall mid-stream
    do_reset();
    for (int unsigned t = 0; t < 90; t++) begin
      cycle(t < 16, word(t), !(t >= 10 && t < 30));
      if (t >= 10 && t < 30) chk("t3_hold_valid", el_valid, 64'(1));
    end
    chk("t3_count", exp_e, 64'(64));
    chk("t3_done_valid", el_valid, 64'(0));
    chk("t3_mc", matrix_count, 64'(1));

    // Fill with el_ready low: almost_full at 28, word 34 dropped
    do_reset();
    for (int unsigned k = 1; k <= 34; k++) begin
      cycle(1'b1, word(k - 1), 1'b0);
      if (k == 28) chk("t4_af_pre", almost_full, 64'(0));
      if (k == 29) chk("t4_af_on", almost_full, 64'(1));
      if (k == 33) chk("t4_ovf_pre", overflow, 64'(0));
      if (k == 34) chk("t4_ovf_on", overflow, 64'(1));
    end
    for (int unsigned i = 0; i < 200 && !(exp_e == 132 && !el_valid); i++) begin
      cycle(1'b0, '0, 1'b1);
    end
    chk("t4_count", exp_e, 64'(132));
    chk("t4_valid", el_valid, 64'(0));
    chk("t4_mc", matrix_count, 64'(2));
    chk("t4_ovf_sticky", overflow, 64'(1));
    chk("t4_busy", busy, 64'(0));

    // Asynchronous reset mid-stream, then a clean matrix from (0,0)
    for (int unsigned t = 0; t < 60 && exp_e < 152; t++) begin
      cycle(t < 16, word(33 + t), 1'b1);
    end
    chk("t5_count", exp_e, 64'(152));
    reset = 1'b0;
    #1;
    chk_all_zero("t5_async");
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_e  = 0;
    exp_mc = '0;
    for (int unsigned t = 0; t < 100 && exp_e < 64; t++) begin
      cycle(t < 16, word(t), 1'b1);
    end
    chk("t5_count2", exp_e, 64'(64));
    chk("t5_mc", matrix_count, 64'(1));
    chk("t5_ovf", overflow, 64'(0));

    // 256 matrices with idle gaps: matrix_count wraps to 0
    do_reset();
    for (int unsigned m = 0; m < 256; m++) begin
      for (int unsigned w = 0; w < 16; w++) begin
        cycle(1'b1, word(m * 16 + w), 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b1);
      end
      repeat (8) cycle(1'b0, '0, 1'b1);
      if (m == 254) chk("t6_mc255", matrix_count, 64'(255));
    end
    chk("t6_count", exp_e, 64'(256 * 64));
    chk("t6_mc_wrap", matrix_count, 64'(0));
    chk("t6_ovf", overflow, 64'(0));
    chk("t6_valid", el_valid, 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
